// File: rtl/da_dct_odd_accum.sv
// Bit-serial distributed-arithmetic accumulator for one odd-row DCT coefficient.
// Walks x0..x3 LSB first, looks up a half coefficient ROM and shift-accumulates.
module da_dct_odd_accum #(
    parameter int unsigned W        = 8,
    parameter int unsigned GUARD    = 7,
    parameter int          INIT_ACC = 0,
    localparam int unsigned ACC_W   = 18 + GUARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x0,
    input  logic [W-1:0]     x1,
    input  logic [W-1:0]     x2,
    input  logic [W-1:0]     x3,
    output logic [2:0]       rom_addr,
    output logic             rom_cs,
    input  logic [15:0]      rom_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] z
);

    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [W-1:0]            x0_q, x0_d;
    logic [W-1:0]            x1_q, x1_d;
    logic [W-1:0]            x2_q, x2_d;
    logic [W-1:0]            x3_q, x3_d;
    logic [CNT_W-1:0]        bit_q, bit_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic [3:0]              slice;
    logic                    last_slice;
    logic signed [ACC_W-1:0] init_ext;
    logic signed [ACC_W-1:0] rom_ext;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] sum;

    // Current bit-slice always sits in bit 0 of the shift registers.
    assign slice      = {x0_q[0], x1_q[0], x2_q[0], x3_q[0]};
    assign last_slice = (bit_q == CNT_W'(W - 1));

    always_comb begin
        init_ext = ACC_W'(INIT_ACC);
        init_ext = init_ext <<< GUARD;
        rom_ext  = {{(ACC_W - 16){rom_data[15]}}, rom_data};
        // Negation happens at full accumulator width so -32768 cannot wrap.
        term     = slice[3] ? -rom_ext : rom_ext;
        term     = term <<< GUARD;
        sum      = acc_q + term;
    end

    always_comb begin
        rom_cs   = 1'b0;
        rom_addr = 3'b000;
        if (state_q == StRun) begin
            rom_cs   = 1'b1;
            rom_addr = slice[3] ? ~slice[2:0] : slice[2:0];
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign z         = acc_q;

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        x3_d    = x3_q;
        bit_d   = bit_q;
        acc_d   = acc_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StRun;
                    x0_d    = x0;
                    x1_d    = x1;
                    x2_d    = x2;
                    x3_d    = x3;
                    bit_d   = '0;
                    acc_d   = init_ext;
                end
            end
            StRun: begin
                x0_d = x0_q >> 1;
                x1_d = x1_q >> 1;
                x2_d = x2_q >> 1;
                x3_d = x3_q >> 1;
                if (last_slice) begin
                    // Sign slice carries negative weight and is not followed by a shift.
                    acc_d   = acc_q - term;
                    bit_d   = '0;
                    state_d = StDone;
                end else begin
                    acc_d = sum >>> 1;
                    bit_d = bit_q + CNT_W'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x0_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            x3_q    <= '0;
            bit_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            x3_q    <= x3_d;
            bit_q   <= bit_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_da_dct_odd_accum.sv
// Scoreboard bench for da_dct_odd_accum with a consistent 8-entry half ROM.
// ROM entries are (-2000 +/-1250 +/-677 +/-250), so z = 4000*x0+2500*x1+1354*x2+500*x3+4177.
module tb_da_dct_odd_accum;

    localparam int W     = 8;
    localparam int ACC_W = 25;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [W-1:0]            x0, x1, x2, x3;
    logic [2:0]              rom_addr;
    logic                    rom_cs;
    logic [15:0]             rom_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] z;

    int total = 0;
    int bad   = 0;
    int n_sent = 0;
    int n_recv = 0;
    int exp_q[$];
    bit stall_en = 1'b0;

    da_dct_odd_accum #(
        .W        (W),
        .GUARD    (7),
        .INIT_ACC (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .rom_addr  (rom_addr),
        .rom_cs    (rom_cs),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rom_fn(input logic [2:0] a);
        case (a)
            3'd0:    return -4177;
            3'd1:    return -3677;
            3'd2:    return -2823;
            3'd3:    return -2323;
            3'd4:    return -1677;
            3'd5:    return -1177;
            3'd6:    return -323;
            default: return 177;
        endcase
    endfunction

    // Garbage when deselected so any use of rom_data outside RUN shows up.
    always_comb begin
        rom_data = 16'hDEAD;
        if (rom_cs) rom_data = 16'(rom_fn(rom_addr));
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int e;
        if (!rst && out_valid && out_ready) begin
            n_recv++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_z: got %0d want no output", int'(z));
            end else begin
                e = exp_q.pop_front();
                chk("z", int'(z), e);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (stall_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input int a, input int b, input int c, input int d,
                        input int e, input bit push);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", int'(in_ready), 1);
        x0 = 8'(a);
        x1 = 8'(b);
        x2 = 8'(c);
        x3 = 8'(d);
        in_valid = 1'b1;
        if (push) begin
            exp_q.push_back(e);
            n_sent++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        x0 = 8'($urandom);
        x1 = 8'($urandom);
        x2 = 8'($urandom);
        x3 = 8'($urandom);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_wait", int'(out_valid), 1);
    endtask

    int vx0[12]  = '{0, -1, 1, 0, 0, 0, 127, -128, 127, -128, 5, -50};
    int vx1[12]  = '{0, -1, 0, 1, 0, 0, 127, -128, -128, 127, -3, 100};
    int vx2[12]  = '{0, -1, 0, 0, 1, 0, 127, -128, 127, -128, 10, -25};
    int vx3[12]  = '{0, -1, 0, 0, 0, 1, 127, -128, -128, 127, -7, 64};
    int vexp[12] = '{4177, -4177, 8177, 6677, 5531, 4677, 1065135, -1065135,
                     300135, -300135, 26717, 52327};

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs_cnt, addr_bad, rdy_bad, n, rcv0, ov_cnt;
        logic signed [7:0] ra, rb, rc, rd;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x0 = '0;
        x1 = '0;
        x2 = '0;
        x3 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_z", int'(z), 0);
        chk("rst_rom_cs", int'(rom_cs), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);

        // Latency and ROM addressing for an all-zero set.
        send(0, 0, 0, 0, 4177, 1'b1);
        cs_cnt = 0;
        addr_bad = 0;
        rdy_bad = 0;
        n = 0;
        while (!out_valid && n < 50) begin
            if (rom_cs) cs_cnt++;
            if (rom_addr != 3'd0) addr_bad++;
            if (in_ready) rdy_bad++;
            @(posedge clk); #1;
            n++;
        end
        chk("run_cycles", cs_cnt, W);
        chk("run_addr_nonzero", addr_bad, 0);
        chk("run_in_ready_high", rdy_bad, 0);
        chk("done_out_valid", int'(out_valid), 1);
        chk("done_rom_cs", int'(rom_cs), 0);
        @(posedge clk); #1;
        chk("idle_after_xfer", int'(in_ready), 1);

        // Backpressure: z held, in_valid ignored, then exactly one transfer.
        out_ready = 1'b0;
        send(1, 0, 0, 0, 8177, 1'b1);
        wait_out();
        rcv0 = n_recv;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            x0 = 8'd0;
            x1 = 8'd1;
            x2 = 8'd0;
            x3 = 8'd0;
            @(posedge clk); #1;
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_z", int'(z), 8177);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        chk("hold_no_xfer", n_recv, rcv0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_no_accept", int'(in_ready), 1);
        exp_q.push_back(6677);
        n_sent++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("accept_in_idle", int'(in_ready), 0);
        chk("single_xfer", n_recv, rcv0 + 1);
        wait_out();
        @(posedge clk); #1;

        // Abort mid-RUN with reset.
        send(0, 0, 1, 0, 5531, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_z", int'(z), 0);
        chk("abort_rom_cs", int'(rom_cs), 0);
        chk("abort_rom_addr", int'(rom_addr), 0);
        ov_cnt = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (out_valid) ov_cnt++;
            @(posedge clk); #1;
        end
        chk("abort_no_output", ov_cnt, 0);
        send(0, 0, 1, 0, 5531, 1'b1);

        // Directed table, first without stalls, then with random stalls.
        for (int i = 0; i < 12; i++) send(vx0[i], vx1[i], vx2[i], vx3[i], vexp[i], 1'b1);
        stall_en = 1'b1;
        for (int i = 0; i < 12; i++) send(vx0[i], vx1[i], vx2[i], vx3[i], vexp[i], 1'b1);
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 8'($urandom);
            rd = 8'($urandom);
            send(int'(ra), int'(rb), int'(rc), int'(rd),
                 4000 * int'(ra) + 2500 * int'(rb) + 1354 * int'(rc) + 500 * int'(rd) + 4177,
                 1'b1);
        end
        @(posedge clk); #1;
        stall_en = 1'b0;
        out_ready = 1'b1;

        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
        chk("xfer_count", n_recv, n_sent);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
